// File: rtl/serializer_pkg.sv
// Shared types and helpers for the multilane serializer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serializer_pkg;

   // Control FSM states: IDLE waits for a word, SHIFT streams it, GAP pads between words.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   // Counter width that never collapses to zero bits for tiny ranges.
   function automatic int clog2_safe(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Widths for the legacy configuration (24-bit words, no gap). Instances with other
   // parameters derive their own widths from clog2_safe.
   localparam int CNT_W = clog2_safe(24);
   localparam int GAP_W = clog2_safe(0);

endpackage

// File: rtl/multilane_serializer_lane_shifter.sv
// One lane: DATA_W shift register that presents one registered bit per cycle.
// Latency: first bit on serial_out the cycle after load.
// Backpressure: none; the parent FSM decides when to load or shift.
//
// Ports: fast_clk_in/reset (async, active-high); load + load_data capture a word and
// present its first bit; shift presents the next bit; with neither, serial_out idles.
module lane_shifter
#(
   parameter int DATA_W     = 24,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
)
(
   input  logic              fast_clk_in,
   input  logic              reset,
   input  logic              load,
   input  logic              shift,
   input  logic [DATA_W-1:0] load_data,
   output logic              serial_out
);

   logic [DATA_W-1:0] sr_q, sr_d;
   logic              bit_q, bit_d;

   // The bit on the pin is held in its own flop, so the shift register only keeps the
   // bits still to come; it moves toward the send end by one place per shift.
   always_comb begin
      sr_d  = sr_q;
      bit_d = IDLE_LEVEL;
      if (load) begin
         if (MSB_FIRST) begin
            bit_d = load_data[DATA_W-1];
            sr_d  = {load_data[DATA_W-2:0], 1'b0};
         end else begin
            bit_d = load_data[0];
            sr_d  = {1'b0, load_data[DATA_W-1:1]};
         end
      end else if (shift) begin
         if (MSB_FIRST) begin
            bit_d = sr_q[DATA_W-1];
            sr_d  = {sr_q[DATA_W-2:0], 1'b0};
         end else begin
            bit_d = sr_q[0];
            sr_d  = {1'b0, sr_q[DATA_W-1:1]};
         end
      end
   end

   always_ff @(posedge fast_clk_in or posedge reset) begin
      if (reset) begin
         sr_q  <= '0;
         bit_q <= IDLE_LEVEL;
      end else begin
         sr_q  <= sr_d;
         bit_q <= bit_d;
      end
   end

   assign serial_out = bit_q;

endmodule

// File: rtl/multilane_serializer.sv
// LANES parallel serializers in lockstep with word clock, frame, done and underrun flags.
// Latency: first bit one cycle after in_valid && in_ready; DATA_W cycles per word.
// Backpressure: in_ready only in IDLE, on the last bit (no gap) or in the final gap cycle.
//
// Ports: fast_clk_in/reset (async, active-high); in_data/in_valid/in_ready word input,
// lane k at [k*DATA_W +: DATA_W]; serial_out one registered bit per lane; frame_out on
// the first bit, slow_clk_out over the first half, done on the last bit, underrun the
// cycle after a word ends with nothing to follow, busy while in SHIFT or GAP.
module multilane_serializer
   import serializer_pkg::*;
#(
   parameter int DATA_W     = 24,
   parameter int LANES      = 1,
   parameter bit MSB_FIRST  = 1'b1,
   parameter int GAP_CYCLES = 0,
   parameter bit IDLE_LEVEL = 1'b0
)
(
   input  logic                    fast_clk_in,
   input  logic                    reset,
   input  logic [LANES*DATA_W-1:0] in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [LANES-1:0]        serial_out,
   output logic                    frame_out,
   output logic                    slow_clk_out,
   output logic                    done,
   output logic                    underrun,
   output logic                    busy
);

   localparam int BCNT_W  = clog2_safe(DATA_W);
   localparam int GCNT_W  = clog2_safe(GAP_CYCLES);
   localparam bit HAS_GAP = (GAP_CYCLES > 0);
   localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);
   localparam logic [BCNT_W-1:0] HALF_BIT = BCNT_W'(DATA_W / 2);
   localparam logic [GCNT_W-1:0] LAST_GAP = GCNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   state_t              state_q, state_d;
   logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [GCNT_W-1:0]   gap_cnt_q, gap_cnt_d;
   logic                frame_q, frame_d;
   logic                slow_q, slow_d;
   logic                done_q, done_d;
   logic                underrun_q, underrun_d;
   logic                busy_q, busy_d;
   logic                last_bit;
   logic                accept;
   logic                shift;

   // Ready depends only on registered state, never on in_valid.
   always_comb begin
      last_bit = (bit_cnt_q == LAST_BIT);
      in_ready = 1'b0;
      case (state_q)
         IDLE:    in_ready = 1'b1;
         SHIFT:   in_ready = !HAS_GAP && last_bit;
         GAP:     in_ready = (gap_cnt_q == LAST_GAP);
         default: in_ready = 1'b0;
      endcase
      accept = in_valid && in_ready;
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      underrun_d = 1'b0;
      shift      = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = SHIFT;
               bit_cnt_d = '0;
            end
         end
         SHIFT: begin
            if (!last_bit) begin
               bit_cnt_d = bit_cnt_q + 1'b1;
               shift     = 1'b1;
            end else if (HAS_GAP) begin
               state_d   = GAP;
               gap_cnt_d = '0;
            end else if (accept) begin
               // Back-to-back: the new word loads straight over the last bit.
               bit_cnt_d = '0;
            end else begin
               state_d    = IDLE;
               underrun_d = 1'b1;
            end
         end
         GAP: begin
            if (gap_cnt_q == LAST_GAP) begin
               if (accept) begin
                  state_d   = SHIFT;
                  bit_cnt_d = '0;
               end else begin
                  state_d    = IDLE;
                  underrun_d = 1'b1;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Flags are computed from the next state so they line up with the bit the
      // lanes present after the same edge.
      frame_d = accept;
      slow_d  = (state_d == SHIFT) && (bit_cnt_d < HALF_BIT);
      done_d  = (state_d == SHIFT) && (bit_cnt_d == LAST_BIT);
      busy_d  = (state_d != IDLE);
   end

   always_ff @(posedge fast_clk_in or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         bit_cnt_q  <= '0;
         gap_cnt_q  <= '0;
         frame_q    <= 1'b0;
         slow_q     <= 1'b0;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         frame_q    <= frame_d;
         slow_q     <= slow_d;
         done_q     <= done_d;
         underrun_q <= underrun_d;
         busy_q     <= busy_d;
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : gen_lane
      lane_shifter #(
         .DATA_W     (DATA_W),
         .MSB_FIRST  (MSB_FIRST),
         .IDLE_LEVEL (IDLE_LEVEL)
      ) u_lane (
         .fast_clk_in (fast_clk_in),
         .reset       (reset),
         .load        (accept),
         .shift       (shift),
         .load_data   (in_data[k*DATA_W +: DATA_W]),
         .serial_out  (serial_out[k])
      );
   end

   assign frame_out    = frame_q;
   assign slow_clk_out = slow_q;
   assign done         = done_q;
   assign underrun     = underrun_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_multilane_serializer.sv
// Bench for multilane_serializer: three configurations share one clock and reset.
// Latency: n/a. Backpressure: the driver holds in_valid until in_ready.
module tb_multilane_serializer;

   typedef struct packed {
      logic [3:0] ser;
      logic       frame;
      logic       slow;
      logic       done;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] din [3];
   logic [2:0]  vld;
   logic [2:0]  rdy_m;

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Instance 0: 24b x1, MSB first, no gap, idle 0
   // Instance 1: 8b x4, LSB first, no gap, idle 0
   // Instance 2: 8b x1, MSB first, 3 gap cycles, idle 1
   for (genvar g = 0; g < 3; g++) begin : gen_dut
      localparam int W = (g == 0) ? 24 : 8;
      localparam int L = (g == 1) ? 4 : 1;
      localparam bit M = (g != 1);
      localparam int G = (g == 2) ? 3 : 0;
      localparam bit I = (g == 2);
      localparam logic [3:0] IDLE_VEC = I ? 4'((1 << L) - 1) : 4'd0;

      logic         rdy_w, frm_w, slow_w, done_w, ur_w, busy_w;
      logic [L-1:0] ser_w;

      exp_t q[$];
      exp_t e;
      bit   ur_act  = 0;
      bit   ur_fire = 0;
      int   ur_wait = 0;
      bit   popped, rdy_exp, busy_exp, acc;
      logic [3:0] v;

      multilane_serializer #(
         .DATA_W     (W),
         .LANES      (L),
         .MSB_FIRST  (M),
         .GAP_CYCLES (G),
         .IDLE_LEVEL (I)
      ) u_dut (
         .fast_clk_in  (clk),
         .reset        (rst),
         .in_data      (din[g][L*W-1:0]),
         .in_valid     (vld[g]),
         .in_ready     (rdy_w),
         .serial_out   (ser_w),
         .frame_out    (frm_w),
         .slow_clk_out (slow_w),
         .done         (done_w),
         .underrun     (ur_w),
         .busy         (busy_w)
      );

      assign rdy_m[g] = rdy_w;

      // Reset must clear outputs without waiting for a clock edge.
      always @(posedge rst) begin
         #1;
         check_eq($sformatf("g%0d_rst_ser", g), 64'(4'(ser_w)), 64'(IDLE_VEC));
         check_eq($sformatf("g%0d_rst_busy", g), 64'(busy_w), 64'd0);
         check_eq($sformatf("g%0d_rst_frame", g), 64'(frm_w), 64'd0);
         check_eq($sformatf("g%0d_rst_slow", g), 64'(slow_w), 64'd0);
         check_eq($sformatf("g%0d_rst_done", g), 64'(done_w), 64'd0);
         check_eq($sformatf("g%0d_rst_underrun", g), 64'(ur_w), 64'd0);
      end

      always @(negedge clk) begin
         if (rst) begin
            q.delete();
            ur_act  = 0;
            ur_fire = 0;
            ur_wait = 0;
         end else begin
            busy_exp = ur_act;
            popped   = 0;
            if (q.size() > 0) begin
               e      = q.pop_front();
               popped = 1;
            end else begin
               e = '{ser: IDLE_VEC, frame: 1'b0, slow: 1'b0, done: 1'b0};
            end
            busy_exp = busy_exp || popped;

            check_eq($sformatf("g%0d_ser", g), 64'(4'(ser_w)), 64'(e.ser));
            check_eq($sformatf("g%0d_frame", g), 64'(frm_w), 64'(e.frame));
            check_eq($sformatf("g%0d_slow", g), 64'(slow_w), 64'(e.slow));
            check_eq($sformatf("g%0d_done", g), 64'(done_w), 64'(e.done));
            check_eq($sformatf("g%0d_underrun", g), 64'(ur_w), 64'(ur_fire));
            check_eq($sformatf("g%0d_busy", g), 64'(busy_w), 64'(busy_exp));
            ur_fire = 0;

            // A finished word opens a window of G gap cycles; the next word may be
            // taken only in the window's final cycle (the last bit itself if G = 0).
            if (popped && e.done) begin
               ur_act  = 1;
               ur_wait = G;
            end
            rdy_exp = (!popped && !ur_act) || (ur_act && ur_wait == 0);
            check_eq($sformatf("g%0d_ready", g), 64'(rdy_w), 64'(rdy_exp));

            acc = vld[g] && rdy_exp;
            if (ur_act) begin
               if (ur_wait == 0) begin
                  ur_act  = 0;
                  ur_fire = !acc;
               end else begin
                  ur_wait--;
               end
            end

            if (acc) begin
               for (int b = 0; b < W; b++) begin
                  v = '0;
                  for (int ln = 0; ln < L; ln++)
                     v[ln] = din[g][ln*W + (M ? (W - 1 - b) : b)];
                  q.push_back('{ser: v, frame: (b == 0), slow: (b < W/2), done: (b == W-1)});
               end
            end
         end
      end
   end

   task automatic send(input int g, input logic [31:0] d);
      int n;
      din[g] = d;
      vld[g] = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rdy_m[g] && n < 300);
      if (!rdy_m[g]) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout g%0d: in_ready never rose, required 1", g);
      end
      @(posedge clk);
      #1;
      vld[g] = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      vld = '0;
      for (int i = 0; i < 3; i++) din[i] = '0;
      #2 rst = 1'b1;
      #20 rst = 1'b0;
      @(posedge clk);
      #1;

      // Single word, MSB first, underrun afterwards
      send(0, 32'hA5C3F0);
      idle_cycles(30);

      // Back-to-back words with no gap
      send(0, 32'hFFFFFF);
      send(0, 32'h000000);
      idle_cycles(30);

      // Four lanes, LSB first
      send(1, 32'h0180FF55);
      idle_cycles(12);

      // Gap of three cycles between queued words, idle level high
      send(2, 32'hA5);
      send(2, 32'h3C);
      idle_cycles(16);

      // Valid toggled with junk data while not ready; held word taken at the boundary
      send(0, 32'h123456);
      for (int i = 0; i < 6; i++) begin
         din[0] = $urandom;
         vld[0] = i[0];
         @(posedge clk);
         #1;
      end
      send(0, 32'h654321);
      idle_cycles(30);

      // Reset mid-word, then a clean restart
      send(0, 32'hABCDEF);
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #15 rst = 1'b0;
      @(posedge clk);
      #1;
      send(0, 32'h5A5A5A);
      idle_cycles(30);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
